// File: rtl/testbench_ls_output_pulse_io.sv
// Avalon-MM output port with atomic set/clear and a single-shot pulse engine
// that inverts selected out_port bits for a programmed number of clk cycles.
// Optional pulse-complete interrupt: define TESTBENCH_LS_OUTPUT_PULSE_IO_PULSE_IRQ_EN.
module testbench_ls_output_pulse_io #(
  parameter int              WIDTH       = 8,
  parameter int              CNT_W       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
`ifdef TESTBENCH_LS_OUTPUT_PULSE_IO_PULSE_IRQ_EN
  output logic             irq,
`endif
  output logic [WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_LEN      = 3'd1;
  localparam logic [2:0] ADDR_TRIGGER  = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             overrun_q, overrun_d;
  logic             done_q, done_d;
  logic             irq_en_q, irq_en_d;
  logic             busy;
  logic             wr;
  logic             trigger;
  logic [WIDTH-1:0] wd;
  logic [31:0]      rd_mux;
  logic             unused_wdata;

  assign wr           = chipselect & ~write_n;
  assign wd           = writedata[WIDTH-1:0];
  assign trigger      = wr && (address == ADDR_TRIGGER);
  assign busy         = (state_q == S_ACTIVE);
  assign unused_wdata = ^writedata;

  // NOTE: every variable gets its hold value first so no path leaves it
  // unassigned; that is what keeps this block free of inferred latches.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    data_d    = data_q;
    mask_d    = mask_q;
    overrun_d = overrun_q;
    done_d    = done_q;
    irq_en_d  = irq_en_q;

    if (wr) begin
      case (address)
        ADDR_DATA:     data_d = wd;
        ADDR_LEN:      len_d  = writedata[CNT_W-1:0];
        ADDR_STATUS: begin
          if (writedata[1]) overrun_d = 1'b0;
          if (writedata[2]) done_d    = 1'b0;
`ifdef TESTBENCH_LS_OUTPUT_PULSE_IO_PULSE_IRQ_EN
          irq_en_d = writedata[3];
`endif
        end
        ADDR_OUTSET:   data_d = data_q | wd;
        ADDR_OUTCLEAR: data_d = data_q & ~wd;
        default: ;
      endcase
    end

    // Pulse engine follows the write decode so its set of done/overrun
    // overrides a same-cycle clear.
    case (state_q)
      S_IDLE: begin
        if (trigger && (|wd)) begin
          mask_d  = wd;
          cnt_d   = (len_q == '0) ? CNT_W'(1) : len_q;
          state_d = S_ACTIVE;
        end
      end
      S_ACTIVE: begin
        if (trigger) overrun_d = 1'b1;
        if (cnt_q <= CNT_W'(1)) begin
          mask_d  = '0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      ADDR_DATA:    rd_mux[WIDTH-1:0] = data_q;
      ADDR_LEN:     rd_mux[CNT_W-1:0] = len_q;
      ADDR_TRIGGER: rd_mux[WIDTH-1:0] = mask_q;
      ADDR_STATUS:  rd_mux[3:0]       = {irq_en_q, done_q, overrun_q, busy};
      default: ;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      len_q     <= CNT_W'(1);
      data_q    <= RESET_VALUE;
      mask_q    <= '0;
      overrun_q <= 1'b0;
      done_q    <= 1'b0;
      irq_en_q  <= 1'b0;
      readdata  <= '0;
      out_port  <= RESET_VALUE;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      done_q    <= done_d;
      irq_en_q  <= irq_en_d;
      readdata  <= rd_mux;
      // Pins come straight from a flop fed by next-state, not from the bus.
      out_port  <= data_d ^ mask_d;
    end
  end

`ifdef TESTBENCH_LS_OUTPUT_PULSE_IO_PULSE_IRQ_EN
  assign irq = done_q & irq_en_q;
`endif

endmodule

// File: tb/tb_testbench_ls_output_pulse_io.sv
// Directed bench for testbench_ls_output_pulse_io: expected values are queued
// when stimulus is applied and popped when the DUT output is sampled.
module tb_testbench_ls_output_pulse_io;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  out_port;
`ifdef TESTBENCH_LS_OUTPUT_PULSE_IO_PULSE_IRQ_EN
  logic        irq;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] rd;

  testbench_ls_output_pulse_io #(.WIDTH(8), .CNT_W(16), .RESET_VALUE(8'h00)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
`ifdef TESTBENCH_LS_OUTPUT_PULSE_IO_PULSE_IRQ_EN
    .irq        (irq),
`endif
    .out_port   (out_port)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_val(input logic [31:0] v);
    sb.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL %s observed=%h expected=<none queued>", tag, obs);
    end else begin
      exp = sb.pop_front();
      assert (obs === exp) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
    end
  endtask

  // Drives one write at a negedge; returns at the negedge after the sampling edge.
  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    @(negedge clk);
    d = readdata;
    chipselect = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    repeat (2) @(negedge clk);

    // Reset state
    expect_val(32'h00); chk("reset_out_port", 32'(out_port));
    expect_val(32'h00); chk("reset_readdata", readdata);
    reset_n = 1'b1;
    expect_val(32'h1); bus_read(3'd1, rd); chk("reset_pulse_len", rd);

    // Level register with atomic set/clear
    expect_val(32'hA5); bus_write(3'd0, 32'hA5); chk("data_write", 32'(out_port));
    expect_val(32'hAF); bus_write(3'd4, 32'h0A); chk("outset", 32'(out_port));
    expect_val(32'h2E); bus_write(3'd5, 32'h81); chk("outclear", 32'(out_port));
    expect_val(32'h2E); bus_read(3'd0, rd); chk("data_readback", rd);
    bus_write(3'd6, 32'hFF);
    expect_val(32'h0); bus_read(3'd6, rd); chk("addr6_reads_zero", rd);

    // Pulse of 3 cycles on bit0
    bus_write(3'd1, 32'd3);
    bus_write(3'd0, 32'h00);
    expect_val(32'h01); bus_write(3'd2, 32'h01); chk("pulse3_c1", 32'(out_port));
    address = 3'd3;
    @(negedge clk);
    expect_val(32'h01); chk("pulse3_c2", 32'(out_port));
    expect_val(32'h1);  chk("pulse3_busy", readdata);
    address = 3'd2;
    @(negedge clk);
    expect_val(32'h01); chk("pulse3_c3", 32'(out_port));
    expect_val(32'h01); chk("pulse3_mask_read", readdata);
    @(negedge clk);
    expect_val(32'h00); chk("pulse3_restored", 32'(out_port));
    expect_val(32'h4); bus_read(3'd3, rd); chk("pulse3_status_done", rd);

    // Zero length behaves as one cycle
    bus_write(3'd3, 32'h4);
    bus_write(3'd1, 32'd0);
    bus_write(3'd0, 32'hFF);
    expect_val(32'h0F); bus_write(3'd2, 32'hF0); chk("len0_c1", 32'(out_port));
    @(negedge clk);
    expect_val(32'hFF); chk("len0_restored", 32'(out_port));

    // Zero-mask trigger is ignored
    bus_write(3'd3, 32'h6);
    bus_write(3'd2, 32'h00);
    expect_val(32'hFF); chk("zero_mask_out", 32'(out_port));
    expect_val(32'h0); bus_read(3'd3, rd); chk("zero_mask_status", rd);

    // Overrun: second trigger during a 5-cycle pulse is ignored
    bus_write(3'd0, 32'h00);
    bus_write(3'd1, 32'd5);
    expect_val(32'h02); bus_write(3'd2, 32'h02); chk("ovr_c1", 32'(out_port));
    expect_val(32'h02); bus_write(3'd2, 32'h04); chk("ovr_c3", 32'(out_port));
    @(negedge clk);
    expect_val(32'h02); chk("ovr_c4", 32'(out_port));
    @(negedge clk);
    expect_val(32'h02); chk("ovr_c5", 32'(out_port));
    @(negedge clk);
    expect_val(32'h00); chk("ovr_restored", 32'(out_port));
    expect_val(32'h6); bus_read(3'd3, rd); chk("ovr_status", rd);
    bus_write(3'd3, 32'h6);
    expect_val(32'h0); bus_read(3'd3, rd); chk("ovr_status_cleared", rd);

    // Reset mid-pulse
    bus_write(3'd1, 32'd10);
    expect_val(32'h01); bus_write(3'd2, 32'h01); chk("rst_pulse_c1", 32'(out_port));
    repeat (3) @(negedge clk);
    expect_val(32'h01); chk("rst_pulse_c4", 32'(out_port));
    reset_n = 1'b0;
    #1;
    expect_val(32'h00); chk("rst_abort_out", 32'(out_port));
    @(negedge clk);
    reset_n = 1'b1;
    expect_val(32'h0); bus_read(3'd3, rd); chk("rst_status", rd);
    expect_val(32'h0); bus_read(3'd2, rd); chk("rst_mask", rd);
    repeat (12) @(negedge clk);
    expect_val(32'h00); chk("rst_no_resume", 32'(out_port));

`ifdef TESTBENCH_LS_OUTPUT_PULSE_IO_PULSE_IRQ_EN
    bus_write(3'd3, 32'h8);
    bus_write(3'd1, 32'd2);
    expect_val(32'h0); bus_write(3'd2, 32'h01); chk("irq_low_busy", 32'(irq));
    repeat (2) @(negedge clk);
    expect_val(32'h1); chk("irq_raised", 32'(irq));
    expect_val(32'hC); bus_read(3'd3, rd); chk("irq_status", rd);
    bus_write(3'd3, 32'h4);
    expect_val(32'h0); chk("irq_cleared", 32'(irq));
`else
    bus_write(3'd3, 32'h8);
    expect_val(32'h0); bus_read(3'd3, rd); chk("no_irq_bit3", rd);
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
